// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_pkg
//  Brief    : Shared opcodes, funct3 size codes, constants and FSM encoding
//             for the MEM pipeline stage.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
    localparam logic [6:0]  OPC_STORE = 7'b0100011;

    localparam logic [2:0]  F3_B  = 3'd0;
    localparam logic [2:0]  F3_H  = 3'd1;
    localparam logic [2:0]  F3_W  = 3'd2;
    localparam logic [2:0]  F3_BU = 3'd4;
    localparam logic [2:0]  F3_HU = 3'd5;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2
    } state_e;

    // Number of bytes moved for a given funct3; unknown codes behave as a word.
    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_load_extend.sv
`default_nettype none
// ============================================================================
//  Module   : load_extend
//  Brief    : Sign/zero extension of an assembled little-endian load word
//             according to funct3.
//  Revision : 1.0 - initial release
// ============================================================================
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [2:0]  funct3,
    output logic [31:0] word_out
);

    // Select extension from funct3; anything unrecognised passes the word through.
    always_comb begin
        word_out = word_in;
        case (funct3)
            F3_B:    word_out = {{24{word_in[7]}},  word_in[7:0]};
            F3_H:    word_out = {{16{word_in[15]}}, word_in[15:0]};
            F3_BU:   word_out = {24'h0, word_in[7:0]};
            F3_HU:   word_out = {16'h0, word_in[15:0]};
            F3_W:    word_out = word_in;
            default: word_out = word_in;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Brief    : MEM pipeline stage with MEM/WB register. Non-memory results pass
//             in one cycle; loads/stores are serialised over a byte-wide RAM
//             port while stall_req holds the upstream pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int         ADDR_W   = 32,
    parameter logic [6:0] OP_LOAD  = OPC_LOAD,
    parameter logic [6:0] OP_STORE = OPC_STORE
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              rdy_in,
    input  logic              in_valid,
    input  logic [4:0]        in_rd_addr,
    input  logic [31:0]       in_result,
    input  logic [31:0]       in_store_data,
    input  logic [6:0]        in_ins_type,
    input  logic [2:0]        in_ins_details,
    output logic              stall_req,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    output logic              out_valid,
    output logic [4:0]        out_rd_addr,
    output logic [31:0]       out_data,
    output logic              forward_mem_enable,
    output logic [4:0]        forward_mem_addr,
    output logic [31:0]       forward_mem_data
);

    state_e            state_q,     state_d;
    logic [2:0]        cnt_q,       cnt_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic [31:0]       rbuf_q,      rbuf_d;
    logic [4:0]        rd_q,        rd_d;
    logic [2:0]        f3_q,        f3_d;
    logic [ADDR_W-1:0] mem_a_q,     mem_a_d;
    logic              mem_wr_q,    mem_wr_d;
    logic [7:0]        mem_dout_q,  mem_dout_d;
    logic              out_valid_q, out_valid_d;
    logic [4:0]        out_rd_q,    out_rd_d;
    logic [31:0]       out_data_q,  out_data_d;

    logic [2:0]        w_size;
    logic [1:0]        w_byte_idx;
    logic [31:0]       w_assembled;
    logic [31:0]       w_extended;
    logic [7:0]        w_store_byte;

    assign w_size       = access_size(f3_q);
    assign w_store_byte = 8'(wdata_q >> {cnt_q, 3'b000});

    // Merge the byte arriving on mem_din into the load buffer; byte k lands
    // two edges after its address was issued, i.e. when cnt_q == k + 2.
    always_comb begin
        w_assembled = rbuf_q;
        w_byte_idx  = 2'(cnt_q - 3'd2);
        if (state_q == ST_LOAD && cnt_q >= 3'd2) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byte_idx == 2'(b)) begin
                    w_assembled[8*b +: 8] = mem_din;
                end
            end
        end
    end

    load_extend u_load_extend (
        .word_in  (w_assembled),
        .funct3   (f3_q),
        .word_out (w_extended)
    );

    // Next-state and MEM/WB register computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        rd_d        = rd_q;
        f3_d        = f3_q;
        mem_a_d     = mem_a_q;
        mem_wr_d    = mem_wr_q;
        mem_dout_d  = mem_dout_q;
        out_valid_d = out_valid_q;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;

        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                if (in_valid) begin
                    if (in_ins_type == OP_LOAD) begin
                        state_d  = ST_LOAD;
                        addr_d   = ADDR_W'(in_result);
                        rd_d     = in_rd_addr;
                        f3_d     = in_ins_details;
                        rbuf_d   = ZeroWord;
                        mem_a_d  = ADDR_W'(in_result);
                        mem_wr_d = 1'b0;
                        cnt_d    = 3'd1;
                    end else if (in_ins_type == OP_STORE) begin
                        state_d    = ST_STORE;
                        addr_d     = ADDR_W'(in_result);
                        wdata_d    = in_store_data;
                        f3_d       = in_ins_details;
                        mem_a_d    = ADDR_W'(in_result);
                        mem_wr_d   = 1'b1;
                        mem_dout_d = in_store_data[7:0];
                        cnt_d      = 3'd1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_rd_d    = in_rd_addr;
                        out_data_d  = in_result;
                    end
                end
            end

            ST_LOAD: begin
                out_valid_d = 1'b0;
                cnt_d       = cnt_q + 3'd1;
                rbuf_d      = w_assembled;
                if (cnt_q < w_size) begin
                    mem_a_d = addr_q + ADDR_W'(cnt_q);
                end
                // Last byte is on mem_din now; retire straight from the merge.
                if (cnt_q == w_size + 3'd1) begin
                    state_d     = ST_IDLE;
                    cnt_d       = 3'd0;
                    out_valid_d = 1'b1;
                    out_rd_d    = rd_q;
                    out_data_d  = w_extended;
                end
            end

            ST_STORE: begin
                out_valid_d = 1'b0;
                if (cnt_q < w_size) begin
                    mem_a_d    = addr_q + ADDR_W'(cnt_q);
                    mem_dout_d = w_store_byte;
                    mem_wr_d   = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                end else begin
                    // Stores retire with rd=0 so nothing is written back.
                    state_d     = ST_IDLE;
                    cnt_d       = 3'd0;
                    mem_wr_d    = 1'b0;
                    out_valid_d = 1'b1;
                    out_rd_d    = 5'd0;
                    out_data_d  = ZeroWord;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                cnt_d    = 3'd0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // State register: synchronous active-low reset, frozen while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= ZeroWord;
            rbuf_q      <= ZeroWord;
            rd_q        <= 5'd0;
            f3_q        <= 3'd0;
            mem_a_q     <= '0;
            mem_wr_q    <= 1'b0;
            mem_dout_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_rd_q    <= 5'd0;
            out_data_q  <= ZeroWord;
        end else if (rdy_in) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            rd_q        <= rd_d;
            f3_q        <= f3_d;
            mem_a_q     <= mem_a_d;
            mem_wr_q    <= mem_wr_d;
            mem_dout_q  <= mem_dout_d;
            out_valid_q <= out_valid_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
        end
    end

    assign stall_req          = (state_q != ST_IDLE);
    assign mem_a              = mem_a_q;
    assign mem_wr             = mem_wr_q;
    assign mem_dout           = mem_dout_q;
    assign out_valid          = out_valid_q;
    assign out_rd_addr        = out_rd_q;
    assign out_data           = out_data_q;
    assign forward_mem_enable = out_valid_q && (out_rd_q != 5'd0);
    assign forward_mem_addr   = out_rd_q;
    assign forward_mem_data   = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Brief    : Self-checking bench for mem_stage with a byte-wide RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;

    logic        clk_in, rst_n, rdy_in, in_valid;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_result, in_store_data;
    logic [6:0]  in_ins_type;
    logic [2:0]  in_ins_details;
    logic        stall_req;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout, mem_din;
    logic        out_valid;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_data;
    logic        forward_mem_enable;
    logic [4:0]  forward_mem_addr;
    logic [31:0] forward_mem_data;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage dut (
        .clk_in             (clk_in),
        .rst_n              (rst_n),
        .rdy_in             (rdy_in),
        .in_valid           (in_valid),
        .in_rd_addr         (in_rd_addr),
        .in_result          (in_result),
        .in_store_data      (in_store_data),
        .in_ins_type        (in_ins_type),
        .in_ins_details     (in_ins_details),
        .stall_req          (stall_req),
        .mem_a              (mem_a),
        .mem_wr             (mem_wr),
        .mem_dout           (mem_dout),
        .mem_din            (mem_din),
        .out_valid          (out_valid),
        .out_rd_addr        (out_rd_addr),
        .out_data           (out_data),
        .forward_mem_enable (forward_mem_enable),
        .forward_mem_addr   (forward_mem_addr),
        .forward_mem_data   (forward_mem_data)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Byte RAM: synchronous write, read data valid one cycle after address.
    logic [7:0] ram [logic [31:0]];
    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a] = mem_dout;
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    end

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " stall_req"}, 32'(stall_req), 32'd0);
        check({tag, " mem_a"},     mem_a,          32'd0);
        check({tag, " mem_wr"},    32'(mem_wr),    32'd0);
        check({tag, " mem_dout"},  32'(mem_dout),  32'd0);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " out_rd"},    32'(out_rd_addr), 32'd0);
        check({tag, " out_data"},  out_data,       32'd0);
        check({tag, " fwd_en"},    32'(forward_mem_enable), 32'd0);
        check({tag, " fwd_addr"},  32'(forward_mem_addr),   32'd0);
        check({tag, " fwd_data"},  forward_mem_data,        32'd0);
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [31:0] sdata;
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
        logic        exp_fwd;
        bit          chk_data;
        int          done_edge;
    } vec_t;

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [4:0] rd,
                                input logic [31:0] sdata, input logic [31:0] exp_data,
                                input logic [4:0] exp_rd, input logic exp_fwd,
                                input bit chk_data, input int done_edge);
        vec_t v;
        v.op = op; v.f3 = f3; v.addr = addr; v.rd = rd; v.sdata = sdata;
        v.exp_data = exp_data; v.exp_rd = exp_rd; v.exp_fwd = exp_fwd;
        v.chk_data = chk_data; v.done_edge = done_edge;
        return v;
    endfunction

    // Present one instruction for a single accept edge, then track it to retirement.
    task automatic run_vec(input string tag, input vec_t v);
        int  cyc;
        int  stalls;
        int  wrs;
        bit  done;
        @(negedge clk_in);
        in_valid = 1'b1; in_ins_type = v.op; in_ins_details = v.f3;
        in_result = v.addr; in_rd_addr = v.rd; in_store_data = v.sdata;
        @(posedge clk_in); #1;
        in_valid = 1'b0;
        cyc = 0; stalls = 0; wrs = 0; done = 1'b0;
        while (!done && cyc <= 20) begin
            if (out_valid) done = 1'b1;
            else begin
                if (stall_req) stalls++;
                if (mem_wr) wrs++;
                @(posedge clk_in); #1;
                cyc++;
            end
        end
        if (!done) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, " done_edge"}, 32'(cyc), 32'(v.done_edge));
        check({tag, " stall_cycles"}, 32'(stalls), 32'(v.done_edge));
        check({tag, " wr_cycles"}, 32'(wrs), (v.op == OP_ST) ? 32'(v.done_edge) : 32'd0);
        check({tag, " stall_at_done"}, 32'(stall_req), 32'd0);
        check({tag, " wr_at_done"}, 32'(mem_wr), 32'd0);
        check({tag, " out_rd"}, 32'(out_rd_addr), 32'(v.exp_rd));
        check({tag, " fwd_en"}, 32'(forward_mem_enable), 32'(v.exp_fwd));
        check({tag, " fwd_addr"}, 32'(forward_mem_addr), 32'(v.exp_rd));
        if (v.chk_data) begin
            check({tag, " out_data"}, out_data, v.exp_data);
            check({tag, " fwd_data"}, forward_mem_data, v.exp_data);
        end
    endtask

    vec_t vecs [17];

    initial begin
        logic [31:0] exp_a [5];
        int c;

        vecs[0]  = mk(OP_ALU, 3'd0, 32'h1234_5678, 5'd5,  32'h0,         32'h1234_5678, 5'd5,  1'b1, 1'b1, 0);
        vecs[1]  = mk(OP_LD,  3'd2, 32'h0000_0100, 5'd3,  32'h0,         32'h1234_5678, 5'd3,  1'b1, 1'b1, 5);
        vecs[2]  = mk(OP_LD,  3'd0, 32'h0000_0020, 5'd7,  32'h0,         32'hFFFF_FF80, 5'd7,  1'b1, 1'b1, 2);
        vecs[3]  = mk(OP_LD,  3'd4, 32'h0000_0020, 5'd7,  32'h0,         32'h0000_0080, 5'd7,  1'b1, 1'b1, 2);
        vecs[4]  = mk(OP_LD,  3'd1, 32'h0000_0200, 5'd9,  32'h0,         32'hFFFF_9A00, 5'd9,  1'b1, 1'b1, 3);
        vecs[5]  = mk(OP_LD,  3'd5, 32'h0000_0200, 5'd9,  32'h0,         32'h0000_9A00, 5'd9,  1'b1, 1'b1, 3);
        vecs[6]  = mk(OP_LD,  3'd2, 32'h0000_0101, 5'd4,  32'h0,         32'hEF12_3456, 5'd4,  1'b1, 1'b1, 5);
        vecs[7]  = mk(OP_ST,  3'd1, 32'hFFFF_FFFF, 5'd11, 32'hAABB_CCDD, 32'h0,         5'd0,  1'b0, 1'b0, 2);
        vecs[8]  = mk(OP_LD,  3'd1, 32'hFFFF_FFFF, 5'd12, 32'h0,         32'hFFFF_CCDD, 5'd12, 1'b1, 1'b1, 3);
        vecs[9]  = mk(OP_ST,  3'd2, 32'h0000_0400, 5'd2,  32'h1122_3344, 32'h0,         5'd0,  1'b0, 1'b0, 4);
        vecs[10] = mk(OP_LD,  3'd2, 32'h0000_0400, 5'd6,  32'h0,         32'h1122_3344, 5'd6,  1'b1, 1'b1, 5);
        vecs[11] = mk(OP_ST,  3'd0, 32'h0000_0300, 5'd1,  32'h1234_5655, 32'h0,         5'd0,  1'b0, 1'b0, 1);
        vecs[12] = mk(OP_LD,  3'd4, 32'h0000_0300, 5'd1,  32'h0,         32'h0000_0055, 5'd1,  1'b1, 1'b1, 2);
        vecs[13] = mk(OP_LD,  3'd2, 32'h0000_0100, 5'd0,  32'h0,         32'h1234_5678, 5'd0,  1'b0, 1'b1, 5);
        vecs[14] = mk(OP_ALU, 3'd0, 32'hDEAD_BEEF, 5'd0,  32'h0,         32'hDEAD_BEEF, 5'd0,  1'b0, 1'b1, 0);
        vecs[15] = mk(OP_LD,  3'd0, 32'h0000_0103, 5'd8,  32'h0,         32'h0000_0012, 5'd8,  1'b1, 1'b1, 2);
        vecs[16] = mk(OP_LD,  3'd1, 32'h0000_0102, 5'd10, 32'h0,         32'h0000_1234, 5'd10, 1'b1, 1'b1, 3);

        ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34;
        ram[32'h103] = 8'h12; ram[32'h104] = 8'hEF; ram[32'h20]  = 8'h80;
        ram[32'h200] = 8'h00; ram[32'h201] = 8'h9A;

        rst_n = 1'b0; rdy_in = 1'b1; in_valid = 1'b0; in_rd_addr = 5'd0;
        in_result = 32'h0; in_store_data = 32'h0; in_ins_type = 7'h0; in_ins_details = 3'd0;
        repeat (3) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        @(negedge clk_in);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        check("ram ffffffff", 32'(ram_rd(32'hFFFF_FFFF)), 32'h0000_00DD);
        check("ram 00000000", 32'(ram_rd(32'h0000_0000)), 32'h0000_00CC);
        check("ram 00000001 untouched", 32'(ram.exists(32'h1)), 32'd0);
        check("ram 00000400", 32'(ram_rd(32'h400)), 32'h44);
        check("ram 00000403", 32'(ram_rd(32'h403)), 32'h11);
        check("ram 00000301 untouched", 32'(ram.exists(32'h301)), 32'd0);

        // LW address trace: one new address per cycle, last one held.
        exp_a = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h103};
        @(negedge clk_in);
        in_valid = 1'b1; in_ins_type = OP_LD; in_ins_details = 3'd2;
        in_result = 32'h100; in_rd_addr = 5'd3;
        @(posedge clk_in); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("lw trace mem_a c%0d", k), mem_a, exp_a[k]);
            check($sformatf("lw trace mem_wr c%0d", k), 32'(mem_wr), 32'd0);
            check($sformatf("lw trace stall c%0d", k), 32'(stall_req), 32'd1);
            @(posedge clk_in); #1;
        end
        check("lw trace out_valid", 32'(out_valid), 32'd1);
        check("lw trace out_data", out_data, 32'h1234_5678);

        // Reset during the second cycle of an LW abandons it.
        @(negedge clk_in);
        in_valid = 1'b1; in_ins_type = OP_LD; in_ins_details = 3'd2;
        in_result = 32'h100; in_rd_addr = 5'd3;
        @(posedge clk_in); #1;
        in_valid = 1'b0;
        @(posedge clk_in); #1;
        rst_n = 1'b0;
        @(posedge clk_in); #1;
        check_all_zero("mid-lw reset");
        rst_n = 1'b1;
        run_vec("post-reset add", mk(OP_ALU, 3'd0, 32'h0BAD_F00D, 5'd13, 32'h0,
                                     32'h0BAD_F00D, 5'd13, 1'b1, 1'b1, 0));

        // rdy_in low for three cycles in the middle of an SW.
        @(negedge clk_in);
        in_valid = 1'b1; in_ins_type = OP_ST; in_ins_details = 3'd2;
        in_result = 32'h500; in_store_data = 32'hCAFE_BABE; in_rd_addr = 5'd14;
        @(posedge clk_in); #1;
        in_valid = 1'b0;
        check("sw c0 mem_a", mem_a, 32'h500);
        check("sw c0 mem_dout", 32'(mem_dout), 32'hBE);
        @(posedge clk_in); #1;
        c = 1;
        check("sw c1 mem_a", mem_a, 32'h501);
        rdy_in = 1'b0;
        repeat (3) begin
            @(posedge clk_in); #1;
            c++;
            check($sformatf("sw frozen c%0d mem_a", c), mem_a, 32'h501);
            check($sformatf("sw frozen c%0d mem_wr", c), 32'(mem_wr), 32'd1);
            check($sformatf("sw frozen c%0d mem_dout", c), 32'(mem_dout), 32'hBA);
            check($sformatf("sw frozen c%0d stall", c), 32'(stall_req), 32'd1);
        end
        rdy_in = 1'b1;
        while (!out_valid && c < 30) begin
            @(posedge clk_in); #1;
            c++;
        end
        check("sw stalled done_edge", 32'(c), 32'd7);
        check("sw stalled fwd_en", 32'(forward_mem_enable), 32'd0);
        check("sw stalled ram 500", 32'(ram_rd(32'h500)), 32'hBE);
        check("sw stalled ram 501", 32'(ram_rd(32'h501)), 32'hBA);
        check("sw stalled ram 502", 32'(ram_rd(32'h502)), 32'hFE);
        check("sw stalled ram 503", 32'(ram_rd(32'h503)), 32'hCA);
        check("sw stalled ram 504 untouched", 32'(ram.exists(32'h504)), 32'd0);

        repeat (2) @(posedge clk_in);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage with MEM/WB output register. Sits between the EX/MEM register and write-back.
- Non-memory results pass through in one cycle.
- Loads and stores are serialised over the byte-wide RAM port. Load bytes are assembled little-endian and sign-/zero-extended.
- The block is the producer of the forward_mem_* bus consumed by the decode/execute register. While an access is in flight it raises stall_req to hold the upstream pipeline.

Parameters:
- ADDR_W, 32: memory address width.
- OP_LOAD, 7'b0000011: ins_type value identifying loads.
- OP_STORE, 7'b0100011: ins_type value identifying stores.

Ports:
- clk_in  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- rdy_in  input  1  global enable; when low, all state and outputs hold.
- in_valid  input  1  EX/MEM holds a valid instruction.
- in_rd_addr  input  5  destination register.
- in_result  input  32  ALU result; this is the byte address for loads/stores.
- in_store_data  input  32  rs2 value for stores.
- in_ins_type  input  7  opcode.
- in_ins_details  input  3  funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- stall_req  output  1  upstream must hold in_* while high.
- mem_a  output  ADDR_W  byte address to RAM.
- mem_wr  output  1  1 = write byte mem_dout.
- mem_dout  output  8  write data byte.
- mem_din  input  8  read data; valid one cycle after its address is presented.
- out_valid  output  1  MEM/WB holds a completed instruction.
- out_rd_addr  output  5  destination register.
- out_data  output  32  write-back value.
- forward_mem_enable  output  1  equals out_valid && out_rd_addr != 0.
- forward_mem_addr  output  5  equals out_rd_addr.
- forward_mem_data  output  32  equals out_data.

Behaviour:
- Reset (rst_n low at posedge):
  - State IDLE, byte counter 0.
  - All outputs 0: stall_req, mem_a, mem_wr, mem_dout, out_valid, out_rd_addr, out_data, forward_mem_*.
  - An access in progress is abandoned. No further mem_wr pulses are issued.
- rdy_in low: no register changes. Outputs hold, including mem_a, mem_wr and the counter.
- FSM states:
  - IDLE: stall_req=0.
  - LOAD: stall_req=1.
  - STORE: stall_req=1.
- Transitions out of IDLE, at an edge with in_valid=1:
  - Non-memory opcode:
    - Stay IDLE.
    - Next cycle: out_valid=1, out_rd_addr=in_rd_addr, out_data=in_result. Latency 1 edge.
  - OP_LOAD: go to LOAD, latch address/rd/funct3, set mem_a=addr, mem_wr=0, cnt=1. out_valid=0.
  - OP_STORE: go to STORE, latch address/data/funct3, set mem_a=addr, mem_wr=1, mem_dout=data[7:0], cnt=1. out_valid=0.
- IDLE with in_valid=0: out_valid=0 next cycle.
- Access size N: 1 for funct3 0/4, 2 for 1/5, 4 for 2.
- LOAD:
  - Address addr+k is presented in the cycle after accept edge E_k, for k = 0..N-1.
  - Byte k is sampled from mem_din at E_{k+2} into result bits [8k+7:8k].
  - At E_{N+1}: result is extended; out_valid=1, out_rd_addr=latched rd; go to IDLE; stall_req drops.
  - LW completes at E_5; LB at E_2.
  - mem_a holds its last address after the address phase ends.
- STORE:
  - Byte k is written in cycle after E_k: mem_a=addr+k, mem_dout=data[8k+7:8k], mem_wr=1.
  - At E_N: mem_wr=0, out_valid=1 with out_rd_addr=0 (no write-back); go to IDLE.
- Extension:
  - funct3 0: sign-extend bit 7.
  - funct3 1: sign-extend bit 15.
  - funct3 4/5: zero-extend.
  - funct3 2: no extension.
  - Other funct3: treat as W.
- Address arithmetic: addr+k wraps modulo 2^ADDR_W. No alignment check; misaligned accesses are legal.
- in_valid while in LOAD/STORE: ignored. Upstream holds it under stall_req. It is accepted in the first IDLE cycle, i.e. the edge after the completion edge.
- rd=0 load: full access is performed, out_valid=1, forward_mem_enable=0.
- Forward outputs are pure functions of MEM/WB registers. No combinational path from in_*.

Decomposition:
- Shared package:
  - OP_LOAD/OP_STORE opcodes.
  - funct3 size codes.
  - ZeroWord constant.
  - FSM state encoding (IDLE=0, LOAD=1, STORE=2).
- One sub-module, load_extend: combinational; inputs 32-bit assembled word and funct3; output the extended 32-bit value.

Test Plan:
- ADD result 0x1234_5678, rd=5, in_valid one cycle -> next cycle out_valid=1, out_data=0x12345678; forward_mem_enable=1, addr=5; stall_req never high.
- LW at 0x100, RAM bytes 78 56 34 12, rd=3 -> mem_a 0x100..0x103 on consecutive cycles, stall_req high 5 cycles; out_data=0x12345678 at E_5.
- LB at 0x20 with byte 0x80, rd=7 -> out_data=0xFFFFFF80. LBU same address -> out_data=0x00000080.
- SH data 0xAABBCCDD to 0xFFFFFFFF -> writes DD@0xFFFFFFFF then CC@0x00000000 (wrap), mem_wr 2 cycles; out_valid with forward_mem_enable=0.
- rst_n low during cycle 2 of an LW -> next cycle all outputs 0, state IDLE. A following ADD completes normally in 1 cycle.
- rdy_in low 3 cycles mid-SW -> mem_a/mem_wr/mem_dout frozen, no extra bytes written. Completion delayed by exactly 3 cycles; RAM contents correct.
